alu_cmd_engine: RTL and testbench

- Sequential initiator for the team's combinational ALU (`ALU #(WIDTH)`, ports A, B, s, c, zero, Of, out).
- Accepts operand/opcode commands over a valid/ready interface and buffers them in a small FIFO.
- Drives the ALU one command at a time, registers its result and flags, and returns them over a valid/ready response interface.
- The ALU is instantiated next to this block; this block owns its A/B/s inputs and consumes its outputs.

---
 rtl/alu_cmd_engine.sv | 202 ++++++++++++++++++++
 tb/tb_alu_cmd_engine.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_engine.sv
// Command engine for the combinational ALU. It queues operand/opcode commands and drives the ALU one at a time.
// It registers each result and returns it. Optional sticky flag accumulation is enabled with `define ALU_STICKY_FLAGS_EN.
module alu_cmd_engine #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [2:0]       cmd_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_s,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_c,
    input  logic             alu_zero,
    input  logic             alu_of,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [2:0]       rsp_flags,
    output logic             busy,
`ifdef ALU_STICKY_FLAGS_EN
    input  logic             sticky_clr,
    output logic [2:0]       sticky_flags,
`endif
    output logic [15:0]      done_count
);

    // Both interfaces use valid/ready. A transfer happens on a rising edge where valid and ready are both high.
    // valid holds its payload stable until that edge.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DRIVE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] fifo_a_q  [DEPTH];
    logic [WIDTH-1:0] fifo_a_d  [DEPTH];
    logic [WIDTH-1:0] fifo_b_q  [DEPTH];
    logic [WIDTH-1:0] fifo_b_d  [DEPTH];
    logic [2:0]       fifo_op_q [DEPTH];
    logic [2:0]       fifo_op_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_s_q, alu_s_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [2:0]       rsp_flags_q, rsp_flags_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [15:0]      done_count_q, done_count_d;
    logic             push;
    logic             pop;

    assign cmd_ready = (count_q != CNT_FULL);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == S_IDLE) && (count_q != '0);

    always_comb begin
        fifo_a_d  = fifo_a_q;
        fifo_b_d  = fifo_b_q;
        fifo_op_d = fifo_op_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push) begin
            fifo_a_d[wr_ptr_q]  = cmd_a;
            fifo_b_d[wr_ptr_q]  = cmd_b;
            fifo_op_d[wr_ptr_q] = cmd_op;
            wr_ptr_d            = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        // A simultaneous push and pop leaves the occupancy unchanged.
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_s_d      = alu_s_q;
        rsp_data_d   = rsp_data_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_valid_d  = rsp_valid_q;
        done_count_d = done_count_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    alu_a_d = fifo_a_q[rd_ptr_q];
                    alu_b_d = fifo_b_q[rd_ptr_q];
                    alu_s_d = fifo_op_q[rd_ptr_q];
                    state_d = S_DRIVE;
                end
            end
            // The ALU is purely combinational. One full cycle passes before its outputs are sampled.
            S_DRIVE: state_d = S_CAPTURE;
            S_CAPTURE: begin
                rsp_data_d  = alu_out;
                rsp_flags_d = {alu_of, alu_zero, alu_c};
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d  = 1'b0;
                    done_count_d = done_count_q + 16'd1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_s_q      <= '0;
            rsp_data_q   <= '0;
            rsp_flags_q  <= '0;
            rsp_valid_q  <= 1'b0;
            done_count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_a_q[i]  <= '0;
                fifo_b_q[i]  <= '0;
                fifo_op_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_s_q      <= alu_s_d;
            rsp_data_q   <= rsp_data_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_valid_q  <= rsp_valid_d;
            done_count_q <= done_count_d;
            fifo_a_q     <= fifo_a_d;
            fifo_b_q     <= fifo_b_d;
            fifo_op_q    <= fifo_op_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_s      = alu_s_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_flags  = rsp_flags_q;
    assign done_count = done_count_q;
    assign busy       = (state_q != S_IDLE) || (count_q != '0);

`ifdef ALU_STICKY_FLAGS_EN
    logic [2:0] sticky_q, sticky_d;

    // If a clear lands on a capture cycle, the clear wins and the new flags are dropped.
    always_comb begin
        sticky_d = sticky_q;
        if (sticky_clr) begin
            sticky_d = '0;
        end else if (state_q == S_CAPTURE) begin
            sticky_d = sticky_q | {alu_of, alu_zero, alu_c};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_flags = sticky_q;
`endif

endmodule

// File: tb/tb_alu_cmd_engine.sv
// Self-checking bench for alu_cmd_engine. A behavioural ALU stands in for the real one.
// Expected responses come from a reference queue. Define ALU_STICKY_FLAGS_EN to also exercise sticky flags.
module tb_alu_cmd_engine;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int RW    = WIDTH + 3;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_s;
    logic [WIDTH-1:0] alu_out;
    logic             alu_c;
    logic             alu_zero;
    logic             alu_of;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [2:0]       rsp_flags;
    logic             busy;
    logic [15:0]      done_count;
`ifdef ALU_STICKY_FLAGS_EN
    logic             sticky_clr;
    logic [2:0]       sticky_flags;
`endif

    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] got_q[$];
    int            hs_cyc_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    bit            sending_done;

    alu_cmd_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_op       (cmd_op),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_s        (alu_s),
        .alu_out      (alu_out),
        .alu_c        (alu_c),
        .alu_zero     (alu_zero),
        .alu_of       (alu_of),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_flags    (rsp_flags),
        .busy         (busy),
`ifdef ALU_STICKY_FLAGS_EN
        .sticky_clr   (sticky_clr),
        .sticky_flags (sticky_flags),
`endif
        .done_count   (done_count)
    );

    // Behavioural ALU. It returns {of, zero, c, out}, the same packing the engine uses for {rsp_flags, rsp_data}.
    function automatic logic [RW-1:0] alu_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic [2:0] s);
        logic [WIDTH:0]   wide;
        logic [WIDTH-1:0] r;
        logic             c;
        logic             of;
        c = 1'b0;
        of = 1'b0;
        wide = '0;
        case (s)
            3'd0: begin
                wide = {1'b0, a} + {1'b0, b};
                r = wide[WIDTH-1:0];
                c = wide[WIDTH];
                of = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            3'd1: begin
                r = a - b;
                c = (a < b);
                of = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: begin r = {a[WIDTH-2:0], 1'b0}; c = a[WIDTH-1]; end
            default: begin r = {1'b0, a[WIDTH-1:1]}; c = a[0]; end
        endcase
        return {of, (r == '0), c, r};
    endfunction

    assign {alu_of, alu_zero, alu_c, alu_out} = alu_ref(alu_a, alu_b, alu_s);

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    // Response monitor: it records every completed handshake and the cycle it happened in.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            got_q.push_back({rsp_flags, rsp_data});
            hs_cyc_q.push_back(cyc);
        end
    end

    // Driver tasks
    task automatic apply_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        cmd_a = '0;
        cmd_b = '0;
        cmd_op = '0;
`ifdef ALU_STICKY_FLAGS_EN
        sticky_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        got_q.delete();
        hs_cyc_q.delete();
    endtask

    task automatic send_cmd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] op,
                            input int bound, output bit acc);
        cmd_valid = 1'b1;
        cmd_a = a;
        cmd_b = b;
        cmd_op = op;
        acc = 1'b0;
        for (int i = 0; i < bound && !acc; i++) begin
            @(negedge clk);
            if (cmd_ready) acc = 1'b1;
            @(posedge clk);
            #1;
        end
        if (acc) exp_q.push_back(alu_ref(a, b, op));
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int bound, output int lat, output bit found);
        found = 1'b0;
        lat = 0;
        while (!found && lat < bound) begin
            @(negedge clk);
            if (rsp_valid) found = 1'b1;
            else lat++;
        end
    endtask

    task automatic wait_drain(input int n, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (got_q.size() >= n) break;
            @(posedge clk);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Tests
    task automatic test_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        cmd_a = '0;
        cmd_b = '0;
        cmd_op = '0;
`ifdef ALU_STICKY_FLAGS_EN
        sticky_clr = 1'b0;
`endif
        @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b exp 1", cmd_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b exp 0", rsp_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
        n_checks++; if (done_count !== 16'h0) begin n_fail++; $display("FAIL reset_done_count: got %h exp 0", done_count); end
        n_checks++; if (alu_a !== 8'h00) begin n_fail++; $display("FAIL reset_alu_a: got %h exp 00", alu_a); end
        n_checks++; if (alu_b !== 8'h00) begin n_fail++; $display("FAIL reset_alu_b: got %h exp 00", alu_b); end
        n_checks++; if (alu_s !== 3'b000) begin n_fail++; $display("FAIL reset_alu_s: got %b exp 000", alu_s); end
        n_checks++; if (rsp_data !== 8'h00) begin n_fail++; $display("FAIL reset_rsp_data: got %h exp 00", rsp_data); end
        n_checks++; if (rsp_flags !== 3'b000) begin n_fail++; $display("FAIL reset_rsp_flags: got %b exp 000", rsp_flags); end
`ifdef ALU_STICKY_FLAGS_EN
        n_checks++; if (sticky_flags !== 3'b000) begin n_fail++; $display("FAIL reset_sticky: got %b exp 000", sticky_flags); end
`endif
        apply_reset();
    endtask

    task automatic test_directed();
        logic [7:0] ta [3];
        logic [7:0] tb_v [3];
        logic [2:0] top [3];
        logic [7:0] ed [3];
        logic [2:0] ef [3];
        bit acc;
        bit found;
        int lat;
        ta = '{8'h23, 8'h23, 8'hFF};
        tb_v = '{8'h21, 8'h21, 8'h01};
        top = '{3'b000, 3'b001, 3'b000};
        ed = '{8'h44, 8'h02, 8'h00};
        ef = '{3'b000, 3'b000, 3'b011};
        apply_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_cmd(ta[i], tb_v[i], top[i], 20, acc);
            n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL dir%0d_accept: got %b exp 1", i, acc); end
            wait_rsp(20, lat, found);
            n_checks++; if (lat != 3) begin n_fail++; $display("FAIL dir%0d_latency: got %0d exp 3", i, lat); end
            n_checks++; if (rsp_data !== ed[i]) begin n_fail++; $display("FAIL dir%0d_data: got %h exp %h", i, rsp_data, ed[i]); end
            n_checks++; if (rsp_flags !== ef[i]) begin n_fail++; $display("FAIL dir%0d_flags: got %b exp %b", i, rsp_flags, ef[i]); end
            n_checks++; if (alu_a !== ta[i]) begin n_fail++; $display("FAIL dir%0d_alu_a: got %h exp %h", i, alu_a, ta[i]); end
            @(posedge clk);
            #1;
            n_checks++; if (done_count !== 16'(i + 1)) begin n_fail++; $display("FAIL dir%0d_done_count: got %0d exp %0d", i, done_count, i + 1); end
            n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL dir%0d_valid_clear: got %b exp 0", i, rsp_valid); end
        end
    endtask

    task automatic test_back_to_back();
        bit acc;
        apply_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_cmd(WIDTH'($urandom_range(0, 255)), WIDTH'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 20, acc);
        end
        wait_drain(4, 60);
        n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL b2b_count: got %0d exp 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_rsp%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        for (int i = 1; i < hs_cyc_q.size(); i++) begin
            n_checks++; if (hs_cyc_q[i] - hs_cyc_q[i-1] != 4) begin n_fail++; $display("FAIL b2b_spacing%0d: got %0d exp 4", i, hs_cyc_q[i] - hs_cyc_q[i-1]); end
        end
    endtask

    task automatic test_random();
        int n_sent;
        n_sent = 0;
        apply_reset();
        sending_done = 1'b0;
        fork
            begin
                bit acc;
                for (int i = 0; i < 40; i++) begin
                    send_cmd(WIDTH'($urandom_range(0, 255)), WIDTH'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 200, acc);
                    if (acc) n_sent++;
                    else begin n_fail++; $display("FAIL rand_accept%0d: got 0 exp 1", i); end
                    n_checks++;
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
                sending_done = 1'b1;
            end
            begin
                while (!sending_done) begin
                    @(posedge clk);
                    #1;
                    rsp_ready = 1'($urandom_range(0, 1));
                end
                rsp_ready = 1'b1;
            end
        join
        wait_drain(n_sent, 400);
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_rsp%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        n_checks++; if (done_count !== 16'(n_sent)) begin n_fail++; $display("FAIL rand_done_count: got %0d exp %0d", done_count, n_sent); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rand_busy_idle: got %b exp 0", busy); end
    endtask

    task automatic test_backpressure();
        bit acc;
        int accepted;
        accepted = 0;
        apply_reset();
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send_cmd(8'h10 + 8'(i), 8'(i * 3 + 1), 3'(i), 12, acc);
            if (acc) accepted++;
        end
        n_checks++; if (accepted != 5) begin n_fail++; $display("FAIL bp_accepted: got %0d exp 5", accepted); end
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_cmd_ready_low: got %b exp 0", cmd_ready); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy: got %b exp 1", busy); end
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_rsp_valid_held: got %b exp 1", rsp_valid); end
        n_checks++; if (alu_a !== 8'h10) begin n_fail++; $display("FAIL bp_alu_a_held: got %h exp 10", alu_a); end
        if (exp_q.size() > 0) begin
            n_checks++; if ({rsp_flags, rsp_data} !== exp_q[0]) begin n_fail++; $display("FAIL bp_rsp_held: got %h exp %h", {rsp_flags, rsp_data}, exp_q[0]); end
        end
        n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL bp_no_early_rsp: got %0d exp 0", got_q.size()); end
        rsp_ready = 1'b1;
        wait_drain(5, 100);
        n_checks++; if (got_q.size() != 5) begin n_fail++; $display("FAIL bp_drain_count: got %0d exp 5", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_rsp%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        n_checks++; if (done_count !== 16'd5) begin n_fail++; $display("FAIL bp_done_count: got %0d exp 5", done_count); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL bp_cmd_ready_back: got %b exp 1", cmd_ready); end
    endtask

    task automatic test_reset_mid();
        bit acc;
        bit found;
        int lat;
        apply_reset();
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_cmd(8'(8'h40 + i), 8'h05, 3'b000, 20, acc);
        end
        wait_rsp(20, lat, found);
        n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL mid_reach_resp: got %b exp 1", found); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b exp 1", busy); end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rsp_valid: got %b exp 0", rsp_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b exp 0", busy); end
        n_checks++; if (done_count !== 16'h0) begin n_fail++; $display("FAIL mid_done_count: got %0d exp 0", done_count); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_cmd_ready: got %b exp 1", cmd_ready); end
        got_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL mid_no_rsp: got %0d exp 0", got_q.size()); end
        n_checks++; if (done_count !== 16'h0) begin n_fail++; $display("FAIL mid_done_after: got %0d exp 0", done_count); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy_after: got %b exp 0", busy); end
    endtask

`ifdef ALU_STICKY_FLAGS_EN
    task automatic test_sticky();
        bit acc;
        bit found;
        int lat;
        apply_reset();
        rsp_ready = 1'b1;
        send_cmd(8'hFF, 8'h01, 3'b000, 20, acc);
        wait_rsp(20, lat, found);
        @(posedge clk);
        #1;
        send_cmd(8'h23, 8'h21, 3'b000, 20, acc);
        wait_rsp(20, lat, found);
        @(posedge clk);
        #1;
        n_checks++; if (sticky_flags !== 3'b011) begin n_fail++; $display("FAIL sticky_accum: got %b exp 011", sticky_flags); end
        sticky_clr = 1'b1;
        @(posedge clk);
        #1;
        sticky_clr = 1'b0;
        n_checks++; if (sticky_flags !== 3'b000) begin n_fail++; $display("FAIL sticky_clear: got %b exp 000", sticky_flags); end
        send_cmd(8'hFF, 8'h01, 3'b000, 20, acc);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        sticky_clr = 1'b1;
        @(posedge clk);
        #1;
        sticky_clr = 1'b0;
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL sticky_capture_seen: got %b exp 1", rsp_valid); end
        n_checks++; if (sticky_flags !== 3'b000) begin n_fail++; $display("FAIL sticky_clear_wins: got %b exp 000", sticky_flags); end
        wait_drain(3, 20);
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_backpressure();
        test_reset_mid();
`ifdef ALU_STICKY_FLAGS_EN
        test_sticky();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
